shim_tx_sched: RTL
==================

# shim_tx_sched

Message-granular scheduler that drains NQ shim FIFOs onto one 64b/66b TX block lane ahead of the PCS encoder. It drives each FIFO's read strobe and muxes the selected head block into a registered output. Grant is held from a start block to its terminate block, so messages from different queues never interleave. Arbitration (round-robin or strict priority) happens only at message boundaries.

## Interface
Parameters:
- NQ, 2 — number of shim queues (2..4)
- MAXLEN, 64 — max blocks per message before forced release
- CNTW, 16 — width of underrun/overrun counters

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- tx_ready  in  1  downstream accepts a block this cycle
- q_empty  in  NQ  per-queue FIFO empty
- q_data_d  in  NQ*64  per-queue head data (queue i at [64i+63:64i])
- q_data_c  in  NQ*2  per-queue head sync header
- q_rd  out  NQ  per-queue read strobe, one-hot or zero, combinational
- out_d  out  64  registered output block data
- out_c  out  2  registered output sync header
- out_valid  out  1  out_d/out_c carry a dequeued block
- grant  out  NQ  one-hot current locked queue; zero when unlocked
- underrun  out  1  pulse: locked queue empty while tx_ready
- overrun  out  1  pulse: MAXLEN forced release
- underrun_cnt  out  CNTW  saturating underrun count
- overrun_cnt  out  CNTW  saturating overrun count

## Operation
- Block classes: sync 2'b10 = data; sync 2'b01 = control, type = data[7:0]. START = type 8'h78. TERM = types 87,99,AA,B4,CC,D2,E1,FF. Any other control block is SINGLE.
- FSM states: IDLE, LOCK.
- IDLE with tx_ready: pick queue s among non-empty per arbitration, assert q_rd[s].
  - Head START -> LOCK with grant=s, len=1.
  - Head TERM/SINGLE/data -> stay IDLE, rr_ptr=s+1 mod NQ.
- IDLE with no non-empty queue or !tx_ready: q_rd=0.
- LOCK with tx_ready and !q_empty[g]: q_rd[g]=1, len+1.
  - TERM read -> IDLE, grant=0, rr_ptr=g+1.
- LOCK with tx_ready and q_empty[g]: q_rd=0, underrun pulse, counter+1; stay LOCK.
- LOCK, read with len==MAXLEN and block not TERM -> IDLE, overrun pulse, counter+1, rr_ptr=g+1.
- !tx_ready: no reads, no underrun, len frozen.
- Round-robin: search starts at rr_ptr, wraps modulo NQ.
- Counters saturate at all-ones.
- len is $clog2(MAXLEN+1) bits.

## Timing
- q_rd is combinational from state, q_empty and tx_ready.
- out_d/out_c/out_valid register the selected head one cycle after q_rd.
- When no read occurred: out_valid=0, out_d=64'h1E, out_c=2'b01 (IDLE block).
- grant updates on the clock edge of the START read, so it is visible the following cycle.
- IDLE-state head read and decision happen in one cycle, so there are no bubbles between back-to-back messages.
- Reset values: state IDLE, grant 0, rr_ptr 0, len 0, out_valid 0, out_d 64'h1E, out_c 2'b01, pulses 0, counters 0.
- Reset mid-message abandons the message; no TERM is synthesized.

## Configuration
- SHIM_SCHED_STRICT_PRIO_EN defined: IDLE selection is the lowest-index non-empty queue; rr_ptr is ignored.
- Undefined: round-robin from rr_ptr as above.
- Lock and MAXLEN behaviour are identical in both builds.

## Structure
- Package shim_pkg holds:
  - SYNC_DATA, SYNC_CTRL
  - BT_START (8'h78) and the TERM type constants
  - D_IDLE
  - block-class enum {BLK_DATA, BLK_START, BLK_TERM, BLK_SINGLE}
- Sub-module shim_blk_classify: combinational, maps (sync, type) to block class; instantiated once on the muxed head.

## Test plan
- Q0 holds START,D,D,TERM and Q1 holds START,D,TERM, both preloaded, tx_ready=1 -> out shows all 4 Q0 blocks then all 3 Q1 blocks contiguously, out_valid=1 for 7 cycles, grant 01 then 10.
- Q0 sends START,D, then empties for 3 cycles before TERM arrives; Q1 non-empty throughout -> no Q1 reads during the gap, underrun pulses 3 times, underrun_cnt=3.
- MAXLEN=4, Q0 sends START plus 6 data blocks -> after the 4th read overrun pulses and state returns to IDLE; the next selection goes to Q1 when Q1 is non-empty.
- tx_ready toggles every other cycle during a Q0 message -> reads only on ready cycles, out_valid=0 in between, len unchanged across stalls.
- Reset asserted mid-LOCK -> grant=0, out_valid=0, out_d=64'h1E immediately; after release a Q1 START is granted.
- Both queues continuously non-empty with SHIM_SCHED_STRICT_PRIO_EN defined -> only Q0 messages are granted; undefined -> Q0 and Q1 messages alternate.

Source files
------------

// File: rtl/shim_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shim_pkg : 64b/66b block constants and block-class type for shim sched   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package shim_pkg;

    localparam logic [1:0]  SYNC_DATA = 2'b10;
    localparam logic [1:0]  SYNC_CTRL = 2'b01;

    localparam logic [7:0]  BT_START  = 8'h78;
    localparam logic [7:0]  BT_TERM0  = 8'h87;
    localparam logic [7:0]  BT_TERM1  = 8'h99;
    localparam logic [7:0]  BT_TERM2  = 8'hAA;
    localparam logic [7:0]  BT_TERM3  = 8'hB4;
    localparam logic [7:0]  BT_TERM4  = 8'hCC;
    localparam logic [7:0]  BT_TERM5  = 8'hD2;
    localparam logic [7:0]  BT_TERM6  = 8'hE1;
    localparam logic [7:0]  BT_TERM7  = 8'hFF;

    localparam logic [63:0] D_IDLE    = 64'h1E;

    typedef enum logic [1:0] {
        BLK_DATA   = 2'd0,
        BLK_START  = 2'd1,
        BLK_TERM   = 2'd2,
        BLK_SINGLE = 2'd3
    } blk_class_t;

    function automatic logic is_term_type(input logic [7:0] btype);
        case (btype)
            BT_TERM0, BT_TERM1, BT_TERM2, BT_TERM3,
            BT_TERM4, BT_TERM5, BT_TERM6, BT_TERM7: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/shim_blk_classify.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shim_blk_classify : maps a 66b block (sync, type) to its block class     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module shim_blk_classify
    import shim_pkg::*;
(
    input  logic [1:0] sync,
    input  logic [7:0] btype,
    output blk_class_t blk_class
);

    // Invalid sync headers (00/11) never open a message, so they fall to SINGLE.
    always_comb begin
        blk_class = BLK_SINGLE;
        if (sync == SYNC_DATA) begin
            blk_class = BLK_DATA;
        end else if (sync == SYNC_CTRL) begin
            if (btype == BT_START) begin
                blk_class = BLK_START;
            end else if (is_term_type(btype)) begin
                blk_class = BLK_TERM;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shim_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shim_tx_sched : message-granular scheduler of NQ shim FIFOs onto one     |
// | 66b TX lane. Define SHIM_SCHED_STRICT_PRIO_EN for strict-priority pick.  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module shim_tx_sched
    import shim_pkg::*;
#(
    parameter int NQ     = 2,
    parameter int MAXLEN = 64,
    parameter int CNTW   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tx_ready,
    input  logic [NQ-1:0]      q_empty,
    input  logic [NQ*64-1:0]   q_data_d,
    input  logic [NQ*2-1:0]    q_data_c,
    output logic [NQ-1:0]      q_rd,
    output logic [63:0]        out_d,
    output logic [1:0]         out_c,
    output logic               out_valid,
    output logic [NQ-1:0]      grant,
    output logic               underrun,
    output logic               overrun,
    output logic [CNTW-1:0]    underrun_cnt,
    output logic [CNTW-1:0]    overrun_cnt
);

    localparam int              QW      = (NQ > 1) ? $clog2(NQ) : 1;
    localparam int              LENW    = $clog2(MAXLEN + 1);
    localparam logic [LENW-1:0] LEN_MAX = LENW'(MAXLEN);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t            r_state;
    logic [NQ-1:0]     r_grant;
    logic [QW-1:0]     r_gidx;
    logic [QW-1:0]     r_rr_ptr;
    logic [LENW-1:0]   r_len;
    logic              r_out_valid;
    logic [63:0]       r_out_d;
    logic [1:0]        r_out_c;
    logic              r_underrun;
    logic              r_overrun;
    logic [CNTW-1:0]   r_underrun_cnt;
    logic [CNTW-1:0]   r_overrun_cnt;

    logic [QW-1:0]     w_pick;
    logic              w_any;
    logic [QW-1:0]     w_sel;
    logic              w_rd;
    logic [63:0]       w_head_d;
    logic [1:0]        w_head_c;
    blk_class_t        w_cls;
    logic [LENW-1:0]   w_len_nxt;

    // Both operands are below NQ, so a single conditional subtract wraps.
    function automatic logic [QW-1:0] wrap_add(input logic [QW-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NQ) begin
            sum = sum - NQ;
        end
        return QW'(sum);
    endfunction

    // Descending scan so the last hit is the highest-priority candidate.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
`ifdef SHIM_SCHED_STRICT_PRIO_EN
        for (int i = NQ - 1; i >= 0; i--) begin
            if (!q_empty[i]) begin
                w_pick = QW'(i);
                w_any  = 1'b1;
            end
        end
`else
        for (int k = NQ - 1; k >= 0; k--) begin
            if (!q_empty[wrap_add(r_rr_ptr, k)]) begin
                w_pick = wrap_add(r_rr_ptr, k);
                w_any  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        w_sel = (r_state == ST_LOCK) ? r_gidx : w_pick;
        w_rd  = tx_ready && ((r_state == ST_LOCK) ? !q_empty[r_gidx] : w_any);
        q_rd  = '0;
        if (w_rd) begin
            q_rd[w_sel] = 1'b1;
        end
        w_head_d  = q_data_d[{w_sel, 6'b0} +: 64];
        w_head_c  = q_data_c[{w_sel, 1'b0} +: 2];
        w_len_nxt = r_len + LENW'(1);
    end

    shim_blk_classify u_classify (
        .sync      (w_head_c),
        .btype     (w_head_d[7:0]),
        .blk_class (w_cls)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_grant        <= '0;
            r_gidx         <= '0;
            r_rr_ptr       <= '0;
            r_len          <= '0;
            r_out_valid    <= 1'b0;
            r_out_d        <= D_IDLE;
            r_out_c        <= SYNC_CTRL;
            r_underrun     <= 1'b0;
            r_overrun      <= 1'b0;
            r_underrun_cnt <= '0;
            r_overrun_cnt  <= '0;
        end else begin
            r_underrun  <= 1'b0;
            r_overrun   <= 1'b0;
            r_out_valid <= w_rd;
            r_out_d     <= w_rd ? w_head_d : D_IDLE;
            r_out_c     <= w_rd ? w_head_c : SYNC_CTRL;

            case (r_state)
                ST_IDLE: begin
                    if (w_rd) begin
                        if (w_cls == BLK_START) begin
                            r_state <= ST_LOCK;
                            r_grant <= q_rd;
                            r_gidx  <= w_pick;
                            r_len   <= LENW'(1);
                        end else begin
                            r_rr_ptr <= wrap_add(w_pick, 1);
                        end
                    end
                end
                ST_LOCK: begin
                    if (tx_ready) begin
                        if (q_empty[r_gidx]) begin
                            r_underrun <= 1'b1;
                            if (r_underrun_cnt != '1) begin
                                r_underrun_cnt <= r_underrun_cnt + CNTW'(1);
                            end
                        end else begin
                            r_len <= w_len_nxt;
                            // A non-TERM block that reaches MAXLEN forces release.
                            if (w_cls == BLK_TERM || w_len_nxt == LEN_MAX) begin
                                r_state  <= ST_IDLE;
                                r_grant  <= '0;
                                r_len    <= '0;
                                r_rr_ptr <= wrap_add(r_gidx, 1);
                                if (w_cls != BLK_TERM) begin
                                    r_overrun <= 1'b1;
                                    if (r_overrun_cnt != '1) begin
                                        r_overrun_cnt <= r_overrun_cnt + CNTW'(1);
                                    end
                                end
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_d        = r_out_d;
    assign out_c        = r_out_c;
    assign out_valid    = r_out_valid;
    assign grant        = r_grant;
    assign underrun     = r_underrun;
    assign overrun      = r_overrun;
    assign underrun_cnt = r_underrun_cnt;
    assign overrun_cnt  = r_overrun_cnt;

endmodule
`default_nettype wire
